coherence_bus_ctrl: RTL and testbench

Sits directly downstream of the two per-core data caches. It arbitrates their memory requests onto the single RAM port and runs the MSI snoop handshake between them. Read and write misses snoop the peer cache. A dirty peer block is transferred cache-to-cache and written back to RAM in the same transaction. Write-backs and flushes go straight to RAM.

---
 rtl/coherence_bus_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
// Two-cache MSI coherence bus controller: arbitrates both data caches onto one
// RAM port, snoops the peer on misses/upgrades and forwards dirty blocks cache-to-cache.
module coherence_bus_ctrl #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        dREN,
  input  logic [1:0]        dWEN,
  input  logic [WORD_W-1:0] daddr0,
  input  logic [WORD_W-1:0] daddr1,
  input  logic [WORD_W-1:0] dstore0,
  input  logic [WORD_W-1:0] dstore1,
  input  logic [1:0]        cctrans,
  input  logic [1:0]        ccwrite,
  output logic [1:0]        dwait,
  output logic [WORD_W-1:0] dload0,
  output logic [WORD_W-1:0] dload1,
  output logic [1:0]        ccwait,
  output logic [1:0]        ccinv,
  output logic [WORD_W-1:0] ccsnoopaddr0,
  output logic [WORD_W-1:0] ccsnoopaddr1,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramwait
);

  typedef enum logic [2:0] {
    IDLE, ARB, WB, SNOOP, C2C0, C2C1, RAMRD0, RAMRD1
  } state_t;

  localparam logic [WORD_W-1:0] ZERO_W = {WORD_W{1'b0}};

  state_t            state_q;
  logic              gnt_q;
  logic              last_q;
  logic              inv_q;
  logic              upg_q;
  logic [WORD_W-1:0] blk_q;

  logic [1:0]        req_s;
  logic              grant_d;
  logic              rsp_s;
  logic [WORD_W-1:0] req_addr_s;
  logic [WORD_W-1:0] req_store_s;
  logic [WORD_W-1:0] rsp_store_s;
  logic [WORD_W-1:0] word_addr_s;
  logic [WORD_W-1:0] rd_data_s;
  logic              done_req_s;
  logic              done_rsp_s;
  logic              ccw_s;

  // An upgrade is cctrans&ccwrite without a strobe; OR-ing it in is equivalent.
  assign req_s       = dREN | dWEN | (cctrans & ccwrite);
  assign rsp_s       = ~gnt_q;
  assign req_addr_s  = gnt_q ? daddr1  : daddr0;
  assign req_store_s = gnt_q ? dstore1 : dstore0;
  assign rsp_store_s = gnt_q ? dstore0 : dstore1;
  assign word_addr_s = ((state_q == C2C1) || (state_q == RAMRD1))
                       ? {blk_q[WORD_W-1:3], 3'b100} : blk_q;

  // Round-robin pick: on a tie the cache that was not served last wins.
  always_comb begin
    if (req_s == 2'b11) begin
      grant_d = ~last_q;
    end else if (req_s[0]) begin
      grant_d = 1'b0;
    end else begin
      grant_d = 1'b1;
    end
  end

  // Transaction FSM with latched requester, block address and request type.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      inv_q   <= 1'b0;
      upg_q   <= 1'b0;
      blk_q   <= ZERO_W;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_s) begin
            gnt_q   <= grant_d;
            state_q <= ARB;
          end
        end
        ARB: begin
          blk_q <= {req_addr_s[WORD_W-1:3], 3'b000};
          inv_q <= ccwrite[gnt_q];
          upg_q <= 1'b0;
          if (dWEN[gnt_q]) begin
            state_q <= WB;
          end else if (dREN[gnt_q]) begin
            state_q <= cctrans[gnt_q] ? SNOOP : RAMRD0;
          end else if (cctrans[gnt_q] && ccwrite[gnt_q]) begin
            state_q <= SNOOP;
            upg_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        WB: begin
          if (!dWEN[gnt_q]) begin
            state_q <= IDLE;
            last_q  <= gnt_q;
          end
        end
        SNOOP: begin
          if (cctrans[rsp_s]) begin
            if (upg_q) begin
              state_q <= IDLE;
              last_q  <= gnt_q;
            end else if (ccwrite[rsp_s]) begin
              state_q <= C2C0;
            end else begin
              state_q <= RAMRD0;
            end
          end
        end
        C2C0: begin
          if (!ramwait) state_q <= C2C1;
        end
        C2C1: begin
          if (!ramwait) begin
            state_q <= IDLE;
            last_q  <= gnt_q;
          end
        end
        RAMRD0: begin
          // A requester that dropped its strobe still gets the word in flight.
          if (!ramwait) begin
            if (dREN[gnt_q]) begin
              state_q <= RAMRD1;
            end else begin
              state_q <= IDLE;
              last_q  <= gnt_q;
            end
          end
        end
        RAMRD1: begin
          if (!ramwait) begin
            state_q <= IDLE;
            last_q  <= gnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM port and completion decode; completion must track ramwait in the same cycle.
  always_comb begin
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = ZERO_W;
    ramstore   = ZERO_W;
    rd_data_s  = ZERO_W;
    done_req_s = 1'b0;
    done_rsp_s = 1'b0;
    ccw_s      = 1'b0;
    case (state_q)
      WB: begin
        if (dWEN[gnt_q]) begin
          ramWEN     = 1'b1;
          ramaddr    = req_addr_s;
          ramstore   = req_store_s;
          done_req_s = ~ramwait;
        end else begin
          ramWEN     = 1'b0;
        end
      end
      SNOOP: begin
        ccw_s      = 1'b1;
        done_req_s = upg_q & cctrans[rsp_s];
      end
      C2C0, C2C1: begin
        ccw_s      = 1'b1;
        ramWEN     = 1'b1;
        ramaddr    = word_addr_s;
        ramstore   = rsp_store_s;
        rd_data_s  = rsp_store_s;
        done_req_s = ~ramwait;
        done_rsp_s = ~ramwait;
      end
      RAMRD0, RAMRD1: begin
        ramREN     = 1'b1;
        ramaddr    = word_addr_s;
        rd_data_s  = ramload;
        done_req_s = ~ramwait;
      end
      default: ccw_s = 1'b0;
    endcase
  end

  // Steer per-role signals onto the requester / responder cache ports.
  always_comb begin
    dwait        = 2'b11;
    ccwait       = 2'b00;
    ccinv        = 2'b00;
    dload0       = ZERO_W;
    dload1       = ZERO_W;
    ccsnoopaddr0 = ZERO_W;
    ccsnoopaddr1 = ZERO_W;
    dwait[gnt_q]  = ~done_req_s;
    dwait[rsp_s]  = ~done_rsp_s;
    ccwait[rsp_s] = ccw_s;
    ccinv[rsp_s]  = ccw_s & inv_q;
    if (gnt_q) begin
      dload1       = rd_data_s;
      ccsnoopaddr0 = ccw_s ? blk_q : ZERO_W;
    end else begin
      dload0       = rd_data_s;
      ccsnoopaddr1 = ccw_s ? blk_q : ZERO_W;
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: directed cache/RAM scenarios push
// expectations into queues that a negedge monitor pops on every DUT response.
module tb_coherence_bus_ctrl;

  logic        CLK;
  logic        RST;
  logic [1:0]  dREN, dWEN, cctrans, ccwrite;
  logic [31:0] daddr0, daddr1, dstore0, dstore1;
  logic [1:0]  dwait, ccwait, ccinv;
  logic [31:0] dload0, dload1, ccsnoopaddr0, ccsnoopaddr1;
  logic        ramREN, ramWEN, ramwait;
  logic [31:0] ramaddr, ramstore, ramload;

  typedef struct packed { logic [31:0] d; logic chk; } rsp_t;
  typedef struct packed { logic we; logic [31:0] a; logic [31:0] d; } ram_t;
  typedef struct packed { logic k; logic [31:0] a; logic inv; } snp_t;

  rsp_t exp0_q[$];
  rsp_t exp1_q[$];
  ram_t ram_q[$];
  snp_t snp_q[$];
  rsp_t mon_rsp;
  ram_t mon_ram;
  snp_t mon_snp;

  int n_cmp = 0;
  int n_err = 0;
  int lat = 0;
  int ram_cnt = 0;
  logic [1:0] ccw_prev = 2'b00;

  coherence_bus_ctrl #(.WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN),
    .daddr0(daddr0), .daddr1(daddr1), .dstore0(dstore0), .dstore1(dstore1),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait),
    .dload0(dload0), .dload1(dload1), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr0(ccsnoopaddr0), .ccsnoopaddr1(ccsnoopaddr1),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramwait(ramwait)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // RAM model: each access is busy for lat cycles, then completes for one cycle.
  assign ramwait = !((ramREN || ramWEN) && (ram_cnt == lat));

  always @(posedge CLK) begin
    if (ramREN || ramWEN) ram_cnt <= (ram_cnt >= lat) ? 0 : ram_cnt + 1;
    else ram_cnt <= 0;
  end

  always_comb begin
    case (ramaddr)
      32'h0000_0100: ramload = 32'h0000_AAAA;
      32'h0000_0104: ramload = 32'h0000_BBBB;
      default:       ramload = {16'h5A5A, ramaddr[15:0]};
    endcase
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got an event, expected none", nm);
  endtask

  task automatic pop_rsp(input int k, input logic [31:0] act);
    if ((k == 0 && exp0_q.size() == 0) || (k == 1 && exp1_q.size() == 0)) begin
      unexpected($sformatf("dwait%0d_pulse", k));
    end else begin
      if (k == 0) mon_rsp = exp0_q.pop_front();
      else mon_rsp = exp1_q.pop_front();
      if (mon_rsp.chk) cmp($sformatf("dload%0d", k), act, mon_rsp.d);
    end
  endtask

  // Monitor: pops and compares on every dwait pulse, RAM completion and snoop start.
  always @(negedge CLK) begin
    if (!RST) begin
      if (!dwait[0]) pop_rsp(0, dload0);
      if (!dwait[1]) pop_rsp(1, dload1);
      if ((ramREN || ramWEN) && !ramwait) begin
        if (ram_q.size() == 0) begin
          unexpected("ram_access");
        end else begin
          mon_ram = ram_q.pop_front();
          cmp("ram_we", 32'(ramWEN), 32'(mon_ram.we));
          cmp("ram_addr", ramaddr, mon_ram.a);
          if (mon_ram.we) cmp("ram_data", ramstore, mon_ram.d);
        end
      end
      if (ramREN || ramWEN) cmp("ram_strobe_excl", 32'(ramREN & ramWEN), 32'h0);
      for (int k = 0; k < 2; k++) begin
        if (ccwait[k] && !ccw_prev[k]) begin
          if (snp_q.size() == 0) begin
            unexpected($sformatf("ccwait%0d", k));
          end else begin
            mon_snp = snp_q.pop_front();
            cmp("snoop_target", 32'(k), 32'(mon_snp.k));
            cmp("snoop_addr", (k == 0) ? ccsnoopaddr0 : ccsnoopaddr1, mon_snp.a);
            cmp("snoop_inv", 32'(ccinv[k]), 32'(mon_snp.inv));
          end
        end
      end
    end
    ccw_prev <= ccwait;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dwait(input int k, input int budget);
    int n;
    n = 0;
    @(negedge CLK);
    while (dwait[k] !== 1'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (dwait[k] !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_dwait%0d: got no pulse, expected one within %0d cycles", k, budget);
    end
  endtask

  task automatic wait_ccwait(input int k, input int budget);
    int n;
    n = 0;
    @(negedge CLK);
    while (ccwait[k] !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (ccwait[k] !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_ccwait%0d: got no snoop, expected one within %0d cycles", k, budget);
    end
  endtask

  task automatic clear_inputs();
    dREN = 2'b00; dWEN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00;
    daddr0 = 32'h0; daddr1 = 32'h0; dstore0 = 32'h0; dstore1 = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_dwait"}, 32'(dwait), 32'h3);
    cmp({tag, "_ccwait"}, 32'(ccwait), 32'h0);
    cmp({tag, "_ram_strobes"}, 32'({ramREN, ramWEN}), 32'h0);
    cmp({tag, "_ramaddr"}, ramaddr, 32'h0);
    cmp({tag, "_dload0"}, dload0, 32'h0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    #2;
    check_reset_outputs("reset");
    tick();
    RST = 1'b0;
    tick();

    // 1: snooped read miss, clean peer, data from RAM
    lat = 0;
    snp_q.push_back('{k: 1'b1, a: 32'h100, inv: 1'b0});
    ram_q.push_back('{we: 1'b0, a: 32'h100, d: 32'h0});
    ram_q.push_back('{we: 1'b0, a: 32'h104, d: 32'h0});
    exp0_q.push_back('{d: 32'h0000_AAAA, chk: 1'b1});
    exp0_q.push_back('{d: 32'h0000_BBBB, chk: 1'b1});
    dREN[0] = 1'b1; daddr0 = 32'h100; cctrans[0] = 1'b1;
    wait_ccwait(1, 20);
    tick();
    cctrans[1] = 1'b1;
    wait_dwait(0, 20);
    tick();
    daddr0 = 32'h104; cctrans[1] = 1'b0;
    wait_dwait(0, 20);
    tick();
    clear_inputs();
    repeat (3) tick();

    // 2: read-exclusive miss from cache1, dirty peer -> cache-to-cache plus write-back
    snp_q.push_back('{k: 1'b0, a: 32'h208, inv: 1'b1});
    ram_q.push_back('{we: 1'b1, a: 32'h208, d: 32'h1111});
    ram_q.push_back('{we: 1'b1, a: 32'h20C, d: 32'h2222});
    exp1_q.push_back('{d: 32'h1111, chk: 1'b1});
    exp1_q.push_back('{d: 32'h2222, chk: 1'b1});
    exp0_q.push_back('{d: 32'h0, chk: 1'b0});
    exp0_q.push_back('{d: 32'h0, chk: 1'b0});
    dREN[1] = 1'b1; daddr1 = 32'h208; cctrans[1] = 1'b1; ccwrite[1] = 1'b1;
    wait_ccwait(0, 20);
    tick();
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; dstore0 = 32'h1111;
    wait_dwait(1, 20);
    cmp("c2c_joint_w0", 32'(dwait), 32'h0);
    tick();
    dstore0 = 32'h2222; daddr1 = 32'h20C;
    wait_dwait(1, 20);
    cmp("c2c_joint_w1", 32'(dwait), 32'h0);
    tick();
    clear_inputs();
    repeat (3) tick();

    // 3: simultaneous plain reads after reset, then a repeated tie
    do_reset();
    ram_q.push_back('{we: 1'b0, a: 32'h400, d: 32'h0});
    ram_q.push_back('{we: 1'b0, a: 32'h404, d: 32'h0});
    ram_q.push_back('{we: 1'b0, a: 32'h500, d: 32'h0});
    ram_q.push_back('{we: 1'b0, a: 32'h504, d: 32'h0});
    ram_q.push_back('{we: 1'b0, a: 32'h600, d: 32'h0});
    ram_q.push_back('{we: 1'b0, a: 32'h604, d: 32'h0});
    exp0_q.push_back('{d: 32'h5A5A_0400, chk: 1'b1});
    exp0_q.push_back('{d: 32'h5A5A_0404, chk: 1'b1});
    exp1_q.push_back('{d: 32'h5A5A_0500, chk: 1'b1});
    exp1_q.push_back('{d: 32'h5A5A_0504, chk: 1'b1});
    exp0_q.push_back('{d: 32'h5A5A_0600, chk: 1'b1});
    exp0_q.push_back('{d: 32'h5A5A_0604, chk: 1'b1});
    dREN = 2'b11; daddr0 = 32'h400; daddr1 = 32'h500;
    wait_dwait(0, 20); tick(); daddr0 = 32'h404;
    wait_dwait(0, 20); tick(); daddr0 = 32'h600;
    wait_dwait(1, 20); tick(); daddr1 = 32'h504;
    wait_dwait(1, 20); tick(); dREN[1] = 1'b0;
    wait_dwait(0, 20); tick(); daddr0 = 32'h604;
    wait_dwait(0, 20); tick();
    clear_inputs();
    repeat (3) tick();

    // 4: two-word write-back with a slow RAM
    lat = 3;
    ram_q.push_back('{we: 1'b1, a: 32'h300, d: 32'hDEAD});
    ram_q.push_back('{we: 1'b1, a: 32'h304, d: 32'hBEEF});
    exp0_q.push_back('{d: 32'h0, chk: 1'b0});
    exp0_q.push_back('{d: 32'h0, chk: 1'b0});
    dWEN[0] = 1'b1; daddr0 = 32'h300; dstore0 = 32'hDEAD;
    wait_dwait(0, 30);
    tick();
    daddr0 = 32'h304; dstore0 = 32'hBEEF;
    wait_dwait(0, 30);
    tick();
    clear_inputs();
    repeat (6) tick();

    // 5: upgrade from cache1, no RAM traffic
    lat = 0;
    snp_q.push_back('{k: 1'b0, a: 32'h808, inv: 1'b1});
    exp1_q.push_back('{d: 32'h0, chk: 1'b0});
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr1 = 32'h80C;
    wait_ccwait(0, 20);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      cmp("upgrade_hold_ccwait0", 32'(ccwait[0]), 32'h1);
    end
    tick();
    cctrans[0] = 1'b1;
    wait_dwait(1, 20);
    tick();
    clear_inputs();
    repeat (3) tick();

    // 6: reset asserted while the second RAM word is still in flight
    lat = 3;
    ram_q.push_back('{we: 1'b0, a: 32'h700, d: 32'h0});
    exp0_q.push_back('{d: 32'h5A5A_0700, chk: 1'b1});
    dREN[0] = 1'b1; daddr0 = 32'h700;
    wait_dwait(0, 30);
    tick();
    daddr0 = 32'h704;
    tick();
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("midrst");
    tick();
    clear_inputs();
    tick();
    RST = 1'b0;
    repeat (6) tick();

    cmp("left_exp0", 32'(exp0_q.size()), 32'h0);
    cmp("left_exp1", 32'(exp1_q.size()), 32'h0);
    cmp("left_ram", 32'(ram_q.size()), 32'h0);
    cmp("left_snoop", 32'(snp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
